// File: rtl/bam_eval_pkg.sv
// Shared types and width helpers for the broken-array multiplier error monitor.
// Widths are functions of the operand width and the window size.
package bam_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bam_state_e;

    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

    function automatic int cnt_w(input int samples_log2);
        return samples_log2 + 1;
    endfunction

    // One extra bit per doubling of the window keeps the sum from overflowing.
    function automatic int sum_w(input int n, input int samples_log2);
        return 2 * n + samples_log2;
    endfunction

    localparam int DEF_N            = 8;
    localparam int DEF_SAMPLES_LOG2 = 8;
    localparam int DEF_PROD_W       = 2 * DEF_N;
    localparam int DEF_CNT_W        = DEF_SAMPLES_LOG2 + 1;
    localparam int DEF_SUM_W        = 2 * DEF_N + DEF_SAMPLES_LOG2;

endpackage

// File: rtl/bam_err_pipe.sv
// Stages S1-S2 of the error monitor: exact product, then absolute difference
// and inequality flag. Operands are folded into the exact product at S1.
module bam_err_pipe
    import bam_eval_pkg::*;
#(
    parameter  int N      = DEF_N,
    localparam int PROD_W = prod_w(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic [PROD_W-1:0] approx,
    output logic              vld_s1,
    output logic              vld_s2,
    output logic [PROD_W-1:0] d,
    output logic              ne
);

    logic [2:1]        vld_pipe;
    logic [PROD_W-1:0] approx_q;
    logic [PROD_W-1:0] exact_q;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[1], in_vld};
    end

    // Data registers only load behind a valid bit; empty slots hold stale data.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            approx_q <= approx;
            exact_q  <= PROD_W'(a) * PROD_W'(b);
        end
        if (vld_pipe[1]) begin
            d  <= (approx_q >= exact_q) ? (approx_q - exact_q) : (exact_q - approx_q);
            ne <= (approx_q != exact_q);
        end
    end

    assign vld_s1 = vld_pipe[1];
    assign vld_s2 = vld_pipe[2];

endmodule

// File: rtl/bam_error_monitor.sv
// Windowed error statistics for an approximate multiplier: window FSM,
// accepted-sample counter and the S3 accumulators around bam_err_pipe.
module bam_error_monitor
    import bam_eval_pkg::*;
#(
    parameter  int N            = DEF_N,
    parameter  int SAMPLES_LOG2 = DEF_SAMPLES_LOG2,
    localparam int PROD_W       = prod_w(N),
    localparam int CNT_W        = cnt_w(SAMPLES_LOG2),
    localparam int SUM_W        = sum_w(N, SAMPLES_LOG2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic [PROD_W-1:0] approx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [PROD_W-1:0] max_abs_err,
    output logic [SUM_W-1:0]  sum_abs_err
);

    localparam logic [CNT_W-1:0] WIN = CNT_W'(1) << SAMPLES_LOG2;

    bam_state_e        state;
    logic [CNT_W-1:0]  accepted;
    logic              xfer;
    logic              vld_s1;
    logic              vld_s2;
    logic [PROD_W-1:0] d;
    logic              ne;

    assign in_ready = (state == RUN) && (accepted < WIN);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    bam_err_pipe #(.N(N)) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .in_vld (xfer),
        .a      (a),
        .b      (b),
        .approx (approx),
        .vld_s1 (vld_s1),
        .vld_s2 (vld_s2),
        .d      (d),
        .ne     (ne)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            accepted    <= '0;
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else begin
            if (vld_s2) begin
                err_count   <= err_count + CNT_W'(ne);
                sum_abs_err <= sum_abs_err + SUM_W'(d);
                if (d > max_abs_err) max_abs_err <= d;
            end
            // The clear below overrides the update above; the pipe is empty then.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        accepted    <= '0;
                        err_count   <= '0;
                        max_abs_err <= '0;
                        sum_abs_err <= '0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        accepted <= accepted + 1'b1;
                        if (accepted == WIN - 1'b1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!vld_s1 && !vld_s2) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bam_error_monitor.sv
// Randomized bench for bam_error_monitor (N=8, 4-sample window) checked
// against a transaction-level model of the window statistics.
module tb_bam_error_monitor;

    localparam int N  = 8;
    localparam int SL = 2;
    localparam int W  = 1 << SL;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, busy, done;
    logic [7:0]  a, b;
    logic [15:0] approx, max_abs_err;
    logic [2:0]  err_count;
    logic [17:0] sum_abs_err;

    int nvec = 0, nerr = 0, cyc_n = 0;

    // model: window active flag, accepted count, cycle of final accept, stats
    bit m_on;
    int m_acc, m_t_last, m_err, m_max, m_sum;

    logic [7:0]  ta  [4] = '{8'd255, 8'd1, 8'd2, 8'd7};
    logic [7:0]  tb  [4] = '{8'd255, 8'd1, 8'd2, 8'd5};
    logic [15:0] tap [4] = '{16'hF000, 16'd0, 16'd4, 16'd40};

    always #5 clk = ~clk;

    bam_error_monitor #(.N(N), .SAMPLES_LOG2(SL)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx(approx), .busy(busy), .done(done),
        .err_count(err_count), .max_abs_err(max_abs_err), .sum_abs_err(sum_abs_err)
    );

    function automatic bit m_ready();
        return m_on && (m_acc < W);
    endfunction
    function automatic bit m_done();
        return m_on && (m_acc == W) && (cyc_n >= m_t_last + 3);
    endfunction
    function automatic bit m_busy();
        return m_on && !m_done();
    endfunction

    task automatic step(input bit s, input bit v, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [15:0] ap);
        bit hon, acc;
        int e, dd;
        @(negedge clk);
        rst = 1'b0; start = s; in_valid = v; a = aa; b = bb; approx = ap;
        hon = s && !m_busy();
        acc = v && m_ready();
        @(posedge clk);
        cyc_n++;
        if (acc) begin
            e  = int'(aa) * int'(bb);
            dd = (int'(ap) > e) ? int'(ap) - e : e - int'(ap);
            m_acc++;
            if (dd != 0) m_err++;
            if (dd > m_max) m_max = dd;
            m_sum += dd;
            if (m_acc == W) m_t_last = cyc_n;
        end
        if (hon) begin
            m_on = 1; m_acc = 0; m_err = 0; m_max = 0; m_sum = 0;
        end
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        cyc_n++;
        m_on = 0; m_acc = 0; m_err = 0; m_max = 0; m_sum = 0;
        #1;
    endtask

    task automatic rnd_sample(output logic [7:0] aa, output logic [7:0] bb, output logic [15:0] ap);
        aa = 8'($urandom);
        bb = 8'($urandom);
        case ($urandom_range(0, 2))
            0:       ap = 16'(aa) * 16'(bb);
            1:       ap = 16'(aa) * 16'(bb) + 16'($urandom_range(1, 300));
            default: ap = 16'($urandom);
        endcase
    endtask

    task automatic test_reset();
        reset_dut();
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready got %b want 0", in_ready); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b want 0", done); end
        nvec++; if (err_count !== 3'd0) begin nerr++; $display("FAIL rst_cnt got %0d want 0", err_count); end
        nvec++; if (max_abs_err !== 16'd0) begin nerr++; $display("FAIL rst_max got %0d want 0", max_abs_err); end
        nvec++; if (sum_abs_err !== 18'd0) begin nerr++; $display("FAIL rst_sum got %0d want 0", sum_abs_err); end
    endtask

    task automatic test_exact();
        logic [7:0] aa, bb;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) begin
            aa = 8'($urandom); bb = 8'($urandom);
            nvec++; if (in_ready !== m_ready()) begin nerr++; $display("FAIL exact_ready got %b want %b", in_ready, m_ready()); end
            step(0, 1, aa, bb, 16'(aa) * 16'(bb));
        end
        for (int i = 0; i < 8 && !m_done(); i++) begin
            nvec++; if (done !== m_done() || busy !== m_busy()) begin nerr++; $display("FAIL exact_drain done/busy got %b%b want %b%b", done, busy, m_done(), m_busy()); end
            step(0, 0, 0, 0, 0);
        end
        nvec++; if (done !== 1'b1 || (cyc_n - m_t_last) != 3) begin nerr++; $display("FAIL exact_done got %b at +%0d want 1 at +3", done, cyc_n - m_t_last); end
        nvec++; if (err_count !== 3'd0 || max_abs_err !== 16'd0 || sum_abs_err !== 18'd0) begin
            nerr++; $display("FAIL exact_stats got %0d/%0d/%0d want 0/0/0", err_count, max_abs_err, sum_abs_err); end
    endtask

    task automatic test_mixed();
        step(1, 1, 8'd9, 8'd9, 16'd0);
        nvec++; if (done !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL mixed_start done/ready got %b%b want 01", done, in_ready); end
        for (int i = 0; i < W; i++) step(0, 1, ta[i], tb[i], tap[i]);
        nvec++; if (in_ready !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL mixed_full ready/busy got %b%b want 01", in_ready, busy); end
        for (int i = 0; i < 8 && !m_done(); i++) step(0, 0, 0, 0, 0);
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL mixed_done got %b want 1", done); end
        nvec++; if (err_count !== 3'd3) begin nerr++; $display("FAIL mixed_cnt got %0d want 3", err_count); end
        nvec++; if (max_abs_err !== 16'd3585) begin nerr++; $display("FAIL mixed_max got %0d want 3585", max_abs_err); end
        nvec++; if (sum_abs_err !== 18'd3591) begin nerr++; $display("FAIL mixed_sum got %0d want 3591", sum_abs_err); end
        step(0, 0, 0, 0, 0);
        nvec++; if (done !== 1'b1 || sum_abs_err !== 18'd3591) begin nerr++; $display("FAIL mixed_hold got %b/%0d want 1/3591", done, sum_abs_err); end
    endtask

    task automatic test_restart();
        logic [7:0] aa, bb;
        step(1, 0, 0, 0, 0);
        nvec++; if (done !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL restart_state done/busy got %b%b want 01", done, busy); end
        nvec++; if (err_count !== 3'd0 || max_abs_err !== 16'd0 || sum_abs_err !== 18'd0) begin
            nerr++; $display("FAIL restart_clear got %0d/%0d/%0d want 0/0/0", err_count, max_abs_err, sum_abs_err); end
        for (int i = 0; i < W; i++) begin
            aa = 8'($urandom); bb = 8'($urandom);
            step(0, 1, aa, bb, 16'(aa) * 16'(bb));
        end
        for (int i = 0; i < 8 && !m_done(); i++) step(0, 0, 0, 0, 0);
        nvec++; if (done !== 1'b1 || err_count !== 3'd0 || max_abs_err !== 16'd0 || sum_abs_err !== 18'd0) begin
            nerr++; $display("FAIL restart_stats got %b %0d/%0d/%0d want 1 0/0/0", done, err_count, max_abs_err, sum_abs_err); end
    endtask

    task automatic test_backpressure();
        logic [7:0] aa, bb;
        logic [15:0] ap;
        bit v;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            v = (i >= 15) ? 1'b1 : 1'($urandom);
            rnd_sample(aa, bb, ap);
            nvec++; if (in_ready !== m_ready() || done !== m_done()) begin
                nerr++; $display("FAIL bp_ctrl cyc %0d ready/done got %b%b want %b%b", i, in_ready, done, m_ready(), m_done()); end
            step(0, v, aa, bb, ap);
        end
        nvec++; if (done !== 1'b1 || m_acc != W) begin nerr++; $display("FAIL bp_done got %b want 1", done); end
        nvec++; if (err_count !== m_err || max_abs_err !== m_max || sum_abs_err !== m_sum) begin
            nerr++; $display("FAIL bp_stats got %0d/%0d/%0d want %0d/%0d/%0d", err_count, max_abs_err, sum_abs_err, m_err, m_max, m_sum); end
    endtask

    task automatic test_start_ignored();
        step(1, 0, 0, 0, 0);
        step(0, 1, ta[0], tb[0], tap[0]);
        step(1, 1, ta[1], tb[1], tap[1]);
        step(0, 1, ta[2], tb[2], tap[2]);
        step(0, 1, ta[3], tb[3], tap[3]);
        step(1, 1, 8'd3, 8'd3, 16'd0);
        for (int i = 0; i < 8 && !m_done(); i++) begin
            nvec++; if (busy !== m_busy()) begin nerr++; $display("FAIL ign_busy got %b want %b", busy, m_busy()); end
            step(0, 0, 0, 0, 0);
        end
        nvec++; if (done !== 1'b1 || err_count !== 3'd3 || max_abs_err !== 16'd3585 || sum_abs_err !== 18'd3591) begin
            nerr++; $display("FAIL ign_stats got %b %0d/%0d/%0d want 1 3/3585/3591", done, err_count, max_abs_err, sum_abs_err); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] aa, bb;
        logic [15:0] ap;
        step(1, 0, 0, 0, 0);
        step(0, 1, ta[0], tb[0], tap[0]);
        step(0, 1, ta[1], tb[1], tap[1]);
        reset_dut();
        nvec++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            nerr++; $display("FAIL mid_ctrl ready/busy/done got %b%b%b want 000", in_ready, busy, done); end
        nvec++; if (err_count !== 3'd0 || max_abs_err !== 16'd0 || sum_abs_err !== 18'd0) begin
            nerr++; $display("FAIL mid_clear got %0d/%0d/%0d want 0/0/0", err_count, max_abs_err, sum_abs_err); end
        step(0, 0, 0, 0, 0);
        nvec++; if (err_count !== 3'd0 || max_abs_err !== 16'd0) begin
            nerr++; $display("FAIL mid_flush got %0d/%0d want 0/0", err_count, max_abs_err); end
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) begin
            rnd_sample(aa, bb, ap);
            step(0, 1, aa, bb, ap);
        end
        for (int i = 0; i < 8 && !m_done(); i++) step(0, 0, 0, 0, 0);
        nvec++; if (done !== 1'b1 || err_count !== m_err || max_abs_err !== m_max || sum_abs_err !== m_sum) begin
            nerr++; $display("FAIL mid_stats got %b %0d/%0d/%0d want 1 %0d/%0d/%0d", done, err_count, max_abs_err, sum_abs_err, m_err, m_max, m_sum); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; approx = '0;
        m_on = 0; m_acc = 0; m_t_last = 0; m_err = 0; m_max = 0; m_sum = 0;
        test_reset();
        test_exact();
        test_mixed();
        test_restart();
        for (int r = 0; r < 4; r++) test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
